// File: rtl/input_cond_pkg.sv
// Shared defaults and counter-width helpers for the input_conditioner slice.
// Optional key auto-repeat is enabled by defining AUTO_REPEAT_EN.
package input_cond_pkg;

  localparam int DEF_N_SW            = 10;
  localparam int DEF_N_KEY           = 4;
  localparam int DEF_DEBOUNCE_CYCLES = 50000;
  localparam int DEF_REPEAT_DELAY    = 25000000;
  localparam int DEF_REPEAT_PERIOD   = 5000000;

  // A 1-bit counter is still needed at the legal minimum of 2 cycles.
  function automatic int deb_cnt_w(input int cycles);
    return (cycles < 2) ? 1 : $clog2(cycles);
  endfunction

  // Hold counter must be able to reach the larger of the two repeat intervals.
  function automatic int rep_cnt_w(input int delay, input int period);
    int m;
    m = (delay > period) ? delay : period;
    return $clog2(m + 1);
  endfunction

  localparam int DEF_DEB_CNT_W = deb_cnt_w(DEF_DEBOUNCE_CYCLES);
  localparam int DEF_REP_CNT_W = rep_cnt_w(DEF_REPEAT_DELAY, DEF_REPEAT_PERIOD);

endpackage

// File: rtl/input_conditioner_debounce_bit.sv
// One input bit: two-flop synchronizer followed by a stable-level debouncer.
// RESET_VAL sets both the synchronizer and the held level at reset.
module debounce_bit
  import input_cond_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter logic RESET_VAL       = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic stable
);

  localparam int CNT_W = deb_cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  // Any return of sync to the held level restarts the count, so glitches vanish.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1  <= RESET_VAL;
      sync2  <= RESET_VAL;
      stable <= RESET_VAL;
      cnt    <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        stable <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/input_conditioner.sv
// Board-pin front end: per-bit sync + debounce, clean levels and event pulses.
// Define AUTO_REPEAT_EN to add held-key auto-repeat on key_press_pulse.
module input_conditioner
  import input_cond_pkg::*;
#(
  parameter int N_SW            = DEF_N_SW,
  parameter int N_KEY           = DEF_N_KEY,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_SW-1:0]  sw_raw,
  input  logic [N_KEY-1:0] key_raw,
  output logic [N_SW-1:0]  sw_clean,
  output logic [N_KEY-1:0] key_pressed,
  output logic [N_KEY-1:0] key_press_pulse,
  output logic [N_KEY-1:0] key_release_pulse,
  output logic             sw_changed
);

  logic [N_SW-1:0]  sw_stable;
  logic [N_SW-1:0]  sw_prev;
  logic [N_KEY-1:0] key_stable;
  logic [N_KEY-1:0] key_prev;
  logic [N_KEY-1:0] press_edge;

  for (genvar i = 0; i < N_SW; i++) begin : g_sw
    debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RESET_VAL       (1'b0)
    ) u_deb (
      .clk     (clk),
      .reset_n (reset_n),
      .raw     (sw_raw[i]),
      .stable  (sw_stable[i])
    );
  end

  // Keys are active-low on the board; their synchronizers reset to released.
  for (genvar i = 0; i < N_KEY; i++) begin : g_key
    debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RESET_VAL       (1'b1)
    ) u_deb (
      .clk     (clk),
      .reset_n (reset_n),
      .raw     (key_raw[i]),
      .stable  (key_stable[i])
    );
  end

  assign sw_clean    = sw_stable;
  assign key_pressed = ~key_stable;

  // Previous-cycle copies reset to the same values as the levels: no pulse on reset release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sw_prev  <= '0;
      key_prev <= '0;
    end else begin
      sw_prev  <= sw_clean;
      key_prev <= key_pressed;
    end
  end

  assign sw_changed        = |(sw_clean ^ sw_prev);
  assign press_edge        = key_pressed & ~key_prev;
  assign key_release_pulse = ~key_pressed & key_prev;

`ifdef AUTO_REPEAT_EN
  localparam int REP_CNT_W = rep_cnt_w(REPEAT_DELAY, REPEAT_PERIOD);
  localparam logic [REP_CNT_W-1:0] DELAY_CNT  = REP_CNT_W'(REPEAT_DELAY);
  localparam logic [REP_CNT_W-1:0] PERIOD_CNT = REP_CNT_W'(REPEAT_PERIOD);

  logic [N_KEY-1:0] rep_fire;

  // hold_cnt counts cycles since the last press/repeat pulse; rep_phase selects
  // the first (delay) or later (period) interval.
  for (genvar i = 0; i < N_KEY; i++) begin : g_rep
    logic [REP_CNT_W-1:0] hold_cnt;
    logic                 rep_phase;

    assign rep_fire[i] = key_pressed[i] &&
                         (rep_phase ? (hold_cnt == PERIOD_CNT) : (hold_cnt == DELAY_CNT));

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        hold_cnt  <= '0;
        rep_phase <= 1'b0;
      end else if (!key_pressed[i]) begin
        hold_cnt  <= '0;
        rep_phase <= 1'b0;
      end else if (press_edge[i]) begin
        hold_cnt  <= REP_CNT_W'(1);
        rep_phase <= 1'b0;
      end else if (rep_fire[i]) begin
        hold_cnt  <= REP_CNT_W'(1);
        rep_phase <= 1'b1;
      end else if (hold_cnt != '0) begin
        hold_cnt <= hold_cnt + REP_CNT_W'(1);
      end
    end
  end

  assign key_press_pulse = press_edge | rep_fire;
`else
  assign key_press_pulse = press_edge;
`endif

endmodule

// File: tb/tb_input_conditioner.sv
// Directed, table-driven bench for input_conditioner with short debounce/repeat
// intervals; AUTO_REPEAT_EN changes the expected repeat pulses.
module tb_input_conditioner;

  localparam int DEB = 4;

`ifdef AUTO_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif
  localparam logic [3:0] REP_K2 = REP ? 4'h4 : 4'h0;

  typedef struct {
    int         n;
    logic [9:0] sw;
    logic [3:0] key;
    logic [9:0] e_sw;
    logic [3:0] e_kp;
    logic [3:0] e_pp;
    logic [3:0] e_rp;
    logic       e_ch;
  } vec_t;

  logic       clk;
  logic       reset_n;
  logic [9:0] sw_raw;
  logic [3:0] key_raw;
  logic [9:0] sw_clean;
  logic [3:0] key_pressed;
  logic [3:0] key_press_pulse;
  logic [3:0] key_release_pulse;
  logic       sw_changed;

  int n_vec;
  int n_err;
  vec_t vecs[$];

  input_conditioner #(
    .N_SW            (10),
    .N_KEY           (4),
    .DEBOUNCE_CYCLES (DEB),
    .REPEAT_DELAY    (8),
    .REPEAT_PERIOD   (3)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .sw_raw            (sw_raw),
    .key_raw           (key_raw),
    .sw_clean          (sw_clean),
    .key_pressed       (key_pressed),
    .key_press_pulse   (key_press_pulse),
    .key_release_pulse (key_release_pulse),
    .sw_changed        (sw_changed)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [9:0] e_sw, input logic [3:0] e_kp,
                       input logic [3:0] e_pp, input logic [3:0] e_rp, input logic e_ch);
    n_vec++;
    if (sw_clean !== e_sw || key_pressed !== e_kp || key_press_pulse !== e_pp ||
        key_release_pulse !== e_rp || sw_changed !== e_ch) begin
      n_err++;
      $display("FAIL %s: got sw_clean=%h key_pressed=%h press=%h release=%h sw_changed=%b, want %h %h %h %h %b",
               name, sw_clean, key_pressed, key_press_pulse, key_release_pulse, sw_changed,
               e_sw, e_kp, e_pp, e_rp, e_ch);
    end
  endtask

  // Driver: one step = sample state after the edge, then drive next inputs.
  task automatic step(input string name, input logic [9:0] sw, input logic [3:0] key,
                      input logic [9:0] e_sw, input logic [3:0] e_kp, input logic [3:0] e_pp,
                      input logic [3:0] e_rp, input logic e_ch);
    @(posedge clk);
    #1;
    check(name, e_sw, e_kp, e_pp, e_rp, e_ch);
    sw_raw  = sw;
    key_raw = key;
  endtask

  initial begin
    n_vec   = 0;
    n_err   = 0;
    reset_n = 1'b0;
    sw_raw  = '0;
    key_raw = 4'hF;

    //            n   sw      key   e_sw    e_kp  e_pp    e_rp  e_ch
    vecs.push_back('{20, 10'h000, 4'hF, 10'h000, 4'h0, 4'h0,   4'h0, 1'b0}); // idle after reset
    vecs.push_back('{ 6, 10'h008, 4'hF, 10'h000, 4'h0, 4'h0,   4'h0, 1'b0}); // sw[3] step
    vecs.push_back('{ 1, 10'h008, 4'hF, 10'h008, 4'h0, 4'h0,   4'h0, 1'b1});
    vecs.push_back('{ 4, 10'h008, 4'hF, 10'h008, 4'h0, 4'h0,   4'h0, 1'b0});
    vecs.push_back('{ 3, 10'h008, 4'hE, 10'h008, 4'h0, 4'h0,   4'h0, 1'b0}); // key0 glitch
    vecs.push_back('{10, 10'h008, 4'hF, 10'h008, 4'h0, 4'h0,   4'h0, 1'b0});
    vecs.push_back('{ 6, 10'h008, 4'hB, 10'h008, 4'h0, 4'h0,   4'h0, 1'b0}); // key2 held 20
    vecs.push_back('{ 1, 10'h008, 4'hB, 10'h008, 4'h4, 4'h4,   4'h0, 1'b0});
    vecs.push_back('{ 7, 10'h008, 4'hB, 10'h008, 4'h4, 4'h0,   4'h0, 1'b0});
    vecs.push_back('{ 1, 10'h008, 4'hB, 10'h008, 4'h4, REP_K2, 4'h0, 1'b0});
    vecs.push_back('{ 2, 10'h008, 4'hB, 10'h008, 4'h4, 4'h0,   4'h0, 1'b0});
    vecs.push_back('{ 1, 10'h008, 4'hB, 10'h008, 4'h4, REP_K2, 4'h0, 1'b0});
    vecs.push_back('{ 2, 10'h008, 4'hB, 10'h008, 4'h4, 4'h0,   4'h0, 1'b0});
    vecs.push_back('{ 1, 10'h008, 4'hF, 10'h008, 4'h4, REP_K2, 4'h0, 1'b0}); // key2 released
    vecs.push_back('{ 2, 10'h008, 4'hF, 10'h008, 4'h4, 4'h0,   4'h0, 1'b0});
    vecs.push_back('{ 1, 10'h008, 4'hF, 10'h008, 4'h4, REP_K2, 4'h0, 1'b0});
    vecs.push_back('{ 2, 10'h008, 4'hF, 10'h008, 4'h4, 4'h0,   4'h0, 1'b0});
    vecs.push_back('{ 1, 10'h008, 4'hF, 10'h008, 4'h0, 4'h0,   4'h4, 1'b0});
    vecs.push_back('{ 3, 10'h008, 4'hF, 10'h008, 4'h0, 4'h0,   4'h0, 1'b0});
    vecs.push_back('{ 6, 10'h000, 4'hF, 10'h008, 4'h0, 4'h0,   4'h0, 1'b0}); // back to 0
    vecs.push_back('{ 1, 10'h000, 4'hF, 10'h000, 4'h0, 4'h0,   4'h0, 1'b1});
    vecs.push_back('{ 3, 10'h000, 4'hF, 10'h000, 4'h0, 4'h0,   4'h0, 1'b0});
    vecs.push_back('{ 6, 10'h2A5, 4'hF, 10'h000, 4'h0, 4'h0,   4'h0, 1'b0}); // multi-bit step
    vecs.push_back('{ 1, 10'h2A5, 4'hF, 10'h2A5, 4'h0, 4'h0,   4'h0, 1'b1});
    vecs.push_back('{ 3, 10'h2A5, 4'hF, 10'h2A5, 4'h0, 4'h0,   4'h0, 1'b0});
    vecs.push_back('{ 6, 10'h2A5, 4'h6, 10'h2A5, 4'h0, 4'h0,   4'h0, 1'b0}); // keys 0,3 together
    vecs.push_back('{ 1, 10'h2A5, 4'hF, 10'h2A5, 4'h9, 4'h9,   4'h0, 1'b0});
    vecs.push_back('{ 5, 10'h2A5, 4'hF, 10'h2A5, 4'h9, 4'h0,   4'h0, 1'b0});
    vecs.push_back('{ 1, 10'h2A5, 4'hF, 10'h2A5, 4'h0, 4'h0,   4'h9, 1'b0});
    vecs.push_back('{ 2, 10'h2A5, 4'hF, 10'h2A5, 4'h0, 4'h0,   4'h0, 1'b0});

    // Reset state while held in reset
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", 10'h000, 4'h0, 4'h0, 4'h0, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;

    foreach (vecs[r]) begin
      for (int j = 0; j < vecs[r].n; j++) begin
        step($sformatf("row%0d.%0d", r, j), vecs[r].sw, vecs[r].key,
             vecs[r].e_sw, vecs[r].e_kp, vecs[r].e_pp, vecs[r].e_rp, vecs[r].e_ch);
      end
    end

    // Asynchronous reset mid-count, cleared without a clock edge
    step("pre_async", 10'h000, 4'h0, 10'h2A5, 4'h0, 4'h0, 4'h0, 1'b0);
    repeat (3) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check("async_reset", 10'h000, 4'h0, 4'h0, 4'h0, 1'b0);

    // Inputs still active across reset release: accepted after 2 + DEB cycles
    sw_raw  = 10'h001;
    key_raw = 4'hE;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk);
      #1;
      if (c < 2 + DEB)
        check($sformatf("held_rst%0d", c), 10'h000, 4'h0, 4'h0, 4'h0, 1'b0);
      else if (c == 2 + DEB)
        check($sformatf("held_rst%0d", c), 10'h001, 4'h1, 4'h1, 4'h0, 1'b1);
      else
        check($sformatf("held_rst%0d", c), 10'h001, 4'h1, 4'h0, 4'h0, 1'b0);
    end
    key_raw = 4'hF;
    repeat (10) @(posedge clk);
    #1;
    check("key0_released", 10'h001, 4'h0, 4'h0, 4'h0, 1'b0);

    // key1 held 30 cycles: repeats at 6+8 then every 3 while debounced-pressed
    for (int c = 0; c < 42; c++) begin
      logic [3:0] e_kp;
      logic [3:0] e_pp;
      logic [3:0] e_rp;
      e_kp = (c >= 6 && c <= 35) ? 4'h2 : 4'h0;
      e_pp = (c == 6 || (REP && c >= 14 && c <= 35 && (c - 14) % 3 == 0)) ? 4'h2 : 4'h0;
      e_rp = (c == 36) ? 4'h2 : 4'h0;
      step($sformatf("hold%0d", c), 10'h001, (c < 30) ? 4'hD : 4'hF,
           10'h001, e_kp, e_pp, e_rp, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
